xmit_serializer: RTL and testbench

- UART transmit engine: accepts a parallel byte on a start pulse and shifts it out on a serial line as an asynchronous frame (start, data LSB first, optional parity, stop).
- Produces the `xmitting` level and `done_xmitting` pulse consumed by the UART status/interrupt flag registers.
- Sits between the CPU-side transmit data register and the `sout` pin.

---
 rtl/xmit_serializer.sv | 157 +++++++++++++++
 tb/tb_xmit_serializer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/xmit_serializer.sv
// UART transmit serializer: start bit, DATA_WIDTH data bits LSB first, stop bit.
// Build option: define XMIT_PARITY_EN to insert an even-parity bit between data and stop.
// All outputs are registered; sout idles high.
module xmit_serializer #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_xmit,
  input  logic [DATA_WIDTH-1:0] xmit_data,
  output logic                  sout,
  output logic                  xmitting,
  output logic                  done_xmitting
);

  localparam int unsigned DivW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
`ifdef XMIT_PARITY_EN
    StParity,
`endif
    StStop
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DivW-1:0]       div_q, div_d;
  logic                  sout_q, sout_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef XMIT_PARITY_EN
  logic                  par_q, par_d;
`endif

  logic bit_last;
  assign bit_last = (div_q == DivLast);

  // Next-state: frame sequencing, bit-period divider and registered line value.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    div_d   = div_q + 1'b1;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef XMIT_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      StIdle: begin
        sout_d = 1'b1;
        busy_d = 1'b0;
        div_d  = '0;
        if (start_xmit) begin
          shift_d = xmit_data;
          state_d = StStart;
          sout_d  = 1'b0;
          busy_d  = 1'b1;
`ifdef XMIT_PARITY_EN
          par_d   = ^xmit_data;
`endif
        end
      end
      StStart: begin
        if (bit_last) begin
          state_d = StData;
          sout_d  = shift_q[0];
          cnt_d   = '0;
          div_d   = '0;
        end
      end
      StData: begin
        if (bit_last) begin
          div_d = '0;
          if (cnt_q == CntLast) begin
`ifdef XMIT_PARITY_EN
            state_d = StParity;
            sout_d  = par_q;
`else
            state_d = StStop;
            sout_d  = 1'b1;
`endif
          end else begin
            shift_d = shift_q >> 1;
            sout_d  = shift_q[1];
            cnt_d   = cnt_q + 1'b1;
          end
        end
      end
`ifdef XMIT_PARITY_EN
      StParity: begin
        if (bit_last) begin
          state_d = StStop;
          sout_d  = 1'b1;
          div_d   = '0;
        end
      end
`endif
      StStop: begin
        sout_d = 1'b1;
        if (bit_last) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          div_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        sout_d  = 1'b1;
        busy_d  = 1'b0;
        div_d   = '0;
      end
    endcase
  end

  // State registers; asynchronous reset forces the line high and abandons any frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      div_q   <= '0;
      sout_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef XMIT_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef XMIT_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign sout          = sout_q;
  assign xmitting      = busy_q;
  assign done_xmitting = done_q;

endmodule

// File: tb/tb_xmit_serializer.sv
// Directed bench for xmit_serializer with CLKS_PER_BIT=4, DATA_WIDTH=8.
// Works in both builds (XMIT_PARITY_EN defined or not).
module tb_xmit_serializer;

  localparam int unsigned DW  = 8;
  localparam int unsigned CPB = 4;
`ifdef XMIT_PARITY_EN
  localparam int NB  = 11;
  localparam bit PAR = 1'b1;
`else
  localparam int NB  = 10;
  localparam bit PAR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start_xmit;
  logic [DW-1:0] xmit_data;
  logic          sout;
  logic          xmitting;
  logic          done_xmitting;

  int checks   = 0;
  int failures = 0;

  xmit_serializer #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_xmit   (start_xmit),
    .xmit_data    (xmit_data),
    .sout         (sout),
    .xmitting     (xmitting),
    .done_xmitting(done_xmitting)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected line bits, index 0 = start bit; p is the hand-computed parity bit.
  function automatic logic [10:0] fr(input logic [7:0] d, input logic p);
    if (PAR) fr = {1'b1, p, d, 1'b0};
    else     fr = {1'b0, 1'b1, d, 1'b0};
  endfunction

  // Present one start_xmit pulse; data is then scrambled to prove it was captured.
  task automatic launch(input logic [7:0] d);
    @(negedge clk);
    start_xmit = 1'b1;
    xmit_data  = d;
    @(posedge clk);
    #1;
    start_xmit = 1'b0;
    xmit_data  = ~d;
  endtask

  // Checks every cycle of a frame whose start edge has just passed, then the done cycle.
  // inject_at >= 0 pulses start_xmit with 8'hFF at that cycle of the frame.
  task automatic watch_frame(input string tag, input logic [10:0] frame, input int inject_at);
    for (int k = 0; k < NB * int'(CPB); k++) begin
      @(negedge clk);
      chk({tag, "_sout"}, 32'(sout), 32'(frame[k / int'(CPB)]));
      chk({tag, "_busy"}, 32'(xmitting), 32'd1);
      chk({tag, "_done_early"}, 32'(done_xmitting), 32'd0);
      if (k == inject_at) begin
        start_xmit = 1'b1;
        xmit_data  = 8'hFF;
      end else begin
        start_xmit = 1'b0;
      end
    end
    @(negedge clk);
    start_xmit = 1'b0;
    chk({tag, "_done"}, 32'(done_xmitting), 32'd1);
    chk({tag, "_busy_end"}, 32'(xmitting), 32'd0);
    chk({tag, "_sout_end"}, 32'(sout), 32'd1);
  endtask

  initial begin
    // Reset held with start_xmit high: outputs stay at reset values.
    rst        = 1'b0;
    start_xmit = 1'b1;
    xmit_data  = 8'hA5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_sout", 32'(sout), 32'd1);
      chk("rst_busy", 32'(xmitting), 32'd0);
      chk("rst_done", 32'(done_xmitting), 32'd0);
    end
    start_xmit = 1'b0;
    rst        = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("idle_sout", 32'(sout), 32'd1);
      chk("idle_busy", 32'(xmitting), 32'd0);
    end

    // 8'hA5: data bits 1,0,1,0,0,1,0,1; even parity 0.
    launch(8'hA5);
    watch_frame("a5", fr(8'hA5, 1'b0), -1);

    // 8'h07: three ones, parity 1.
    launch(8'h07);
    watch_frame("x07", fr(8'h07, 1'b1), -1);

    // start_xmit with 8'hFF at cycle 10 of an 8'h00 frame is ignored.
    launch(8'h00);
    watch_frame("busy", fr(8'h00, 1'b0), 9);
    repeat (3 * CPB) begin
      @(negedge clk);
      chk("busy_no_second_done", 32'(done_xmitting), 32'd0);
      chk("busy_no_second_frame", 32'(xmitting), 32'd0);
      chk("busy_line_idle", 32'(sout), 32'd1);
    end

    // Back-to-back: start_xmit in the done cycle starts the next frame at that edge.
    launch(8'hA5);
    watch_frame("b2b_first", fr(8'hA5, 1'b0), -1);
    start_xmit = 1'b1;
    xmit_data  = 8'h3C;
    @(posedge clk);
    #1;
    start_xmit = 1'b0;
    xmit_data  = 8'h00;
    watch_frame("b2b_second", fr(8'h3C, 1'b0), -1);

    // Reset in the middle of the data bits of 8'h55.
    launch(8'h55);
    repeat (14) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_sout", 32'(sout), 32'd1);
    chk("midrst_busy", 32'(xmitting), 32'd0);
    chk("midrst_done", 32'(done_xmitting), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (NB * int'(CPB) + 4) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done_xmitting), 32'd0);
      chk("midrst_line_idle", 32'(sout), 32'd1);
    end
    launch(8'h55);
    watch_frame("after_rst", fr(8'h55, 1'b0), -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
